stream_password_checker: RTL and testbench

//  - Byte-serial password checker: classifies each ASCII char streamed in while en=1 as vowel/consonant/other.
//  - Keeps live vowel and consonant counts; when en drops, snapshots the final counts and evaluates the password.
//  - Sits between the character source (UART/keypad front end) and the status/display logic.

---
 rtl/stream_password_checker.sv | 97 +++++++++
 tb/tb_stream_password_checker.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_password_checker.sv
// ============================================================================
// Module      : stream_password_checker
// Description : Byte-serial password checker. Counts vowels and consonants
//               while en is high and evaluates the password when en drops.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stream_password_checker #(
    parameter int MIN_VOWELS     = 2,
    parameter int MIN_CONSONANTS = 3,
    parameter int CNT_W          = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [7:0]       data_in,
    output logic [CNT_W-1:0] vowels,
    output logic [CNT_W-1:0] consonants,
    output logic [CNT_W-1:0] data_read_vowels,
    output logic [CNT_W-1:0] data_read_consonants,
    output logic             check
);

    localparam logic [CNT_W-1:0] c_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_MIN_V = CNT_W'(MIN_VOWELS);
    localparam logic [CNT_W-1:0] c_MIN_C = CNT_W'(MIN_CONSONANTS);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_COUNT = 1'b1
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_vowels;
    logic [CNT_W-1:0] r_consonants;
    logic [CNT_W-1:0] r_data_read_vowels;
    logic [CNT_W-1:0] r_data_read_consonants;
    logic             r_check;

    logic [7:0] w_lower;
    logic       w_is_letter;
    logic       w_is_vowel;
    logic       w_is_consonant;

    // Setting bit 5 folds upper case onto lower case; non-letters never land in a..z.
    assign w_lower        = data_in | 8'h20;
    assign w_is_letter    = (w_lower >= 8'h61) && (w_lower <= 8'h7A);
    assign w_is_vowel     = (w_lower == 8'h61) || (w_lower == 8'h65) || (w_lower == 8'h69) ||
                            (w_lower == 8'h6F) || (w_lower == 8'h75);
    assign w_is_consonant = w_is_letter && !w_is_vowel;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state                <= S_IDLE;
            r_vowels               <= '0;
            r_consonants           <= '0;
            r_data_read_vowels     <= '0;
            r_data_read_consonants <= '0;
            r_check                <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (en) begin
                        r_vowels     <= w_is_vowel     ? c_ONE : '0;
                        r_consonants <= w_is_consonant ? c_ONE : '0;
                        r_state      <= S_COUNT;
                    end
                end
                S_COUNT: begin
                    if (en) begin
                        if (w_is_vowel && (r_vowels != c_MAX))
                            r_vowels <= r_vowels + c_ONE;
                        if (w_is_consonant && (r_consonants != c_MAX))
                            r_consonants <= r_consonants + c_ONE;
                    end else begin
                        r_data_read_vowels     <= r_vowels;
                        r_data_read_consonants <= r_consonants;
                        r_check                <= (r_vowels >= c_MIN_V) && (r_consonants >= c_MIN_C);
                        r_state                <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign vowels               = r_vowels;
    assign consonants           = r_consonants;
    assign data_read_vowels     = r_data_read_vowels;
    assign data_read_consonants = r_data_read_consonants;
    assign check                = r_check;

endmodule

`default_nettype wire

// File: tb/tb_stream_password_checker.sv
// ============================================================================
// Module      : tb_stream_password_checker
// Description : Scoreboard bench for stream_password_checker with a
//               string-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stream_password_checker;

    localparam int CNT_W = 8;
    localparam int MIN_V = 2;
    localparam int MIN_C = 3;
    localparam int SAT   = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             en = 1'b0;
    logic [7:0]       data_in = 8'h00;
    logic [CNT_W-1:0] vowels;
    logic [CNT_W-1:0] consonants;
    logic [CNT_W-1:0] data_read_vowels;
    logic [CNT_W-1:0] data_read_consonants;
    logic             check;

    stream_password_checker #(
        .MIN_VOWELS    (MIN_V),
        .MIN_CONSONANTS(MIN_C),
        .CNT_W         (CNT_W)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .en                  (en),
        .data_in             (data_in),
        .vowels              (vowels),
        .consonants          (consonants),
        .data_read_vowels    (data_read_vowels),
        .data_read_consonants(data_read_consonants),
        .check               (check)
    );

    always #5 clk = ~clk;

    typedef struct {
        int v;
        int c;
        int dv;
        int dc;
        int chk;
    } exp_t;

    typedef logic [7:0] bytes_t[$];

    exp_t sb[$];
    exp_t last;
    bit   have_last = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    // Reference: count letters of the whole password, clip at the counter ceiling.
    function automatic exp_t model(input bytes_t pw);
        exp_t e;
        int   nv = 0;
        int   nc = 0;
        foreach (pw[i]) begin
            logic [7:0] ch = pw[i];
            if (ch >= "A" && ch <= "Z") ch = ch + 8'd32;
            if (ch == "a" || ch == "e" || ch == "i" || ch == "o" || ch == "u") nv++;
            else if (ch >= "a" && ch <= "z") nc++;
        end
        if (nv > SAT) nv = SAT;
        if (nc > SAT) nc = SAT;
        e.v = nv; e.c = nc; e.dv = nv; e.dc = nc;
        e.chk = (nv >= MIN_V && nc >= MIN_C) ? 1 : 0;
        return e;
    endfunction

    function automatic bytes_t str2q(input string s);
        bytes_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        return q;
    endfunction

    function automatic exp_t zero_exp();
        exp_t e;
        e.v = 0; e.c = 0; e.dv = 0; e.dc = 0; e.chk = 0;
        return e;
    endfunction

    task automatic cmp(input string nm, input logic [31:0] act, input int exp);
        n_vec++;
        if (act !== 32'(exp)) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp_all(input string tag, input exp_t e);
        cmp({tag, ".vowels"},     32'(vowels),               e.v);
        cmp({tag, ".consonants"}, 32'(consonants),           e.c);
        cmp({tag, ".dr_vowels"},  32'(data_read_vowels),     e.dv);
        cmp({tag, ".dr_cons"},    32'(data_read_consonants), e.dc);
        cmp({tag, ".check"},      32'(check),                e.chk);
    endtask

    task automatic pop_and_check(input string tag);
        if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: output event with empty scoreboard at %0t", tag, $time);
        end else begin
            exp_t e = sb.pop_front();
            cmp_all(tag, e);
            last      = e;
            have_last = 1'b1;
        end
    endtask

    // Monitor: decides when the DUT must present a result purely from the
    // sampled input protocol, then checks against the scoreboard.
    initial begin
        bit in_pw = 1'b0;
        logic rs;
        logic es;
        forever begin
            @(posedge clk);
            rs = reset;
            es = en;
            #1;
            if (!rs) begin
                in_pw = 1'b0;
                pop_and_check("reset");
            end else if (es) begin
                in_pw = 1'b1;
            end else if (in_pw) begin
                in_pw = 1'b0;
                pop_and_check("done");
            end else if (have_last) begin
                cmp_all("idle", last);
            end
        end
    end

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            reset = 1'b0;
            en    = 1'b0;
            sb.push_back(zero_exp());
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic stream(input bytes_t pw);
        foreach (pw[i]) begin
            @(negedge clk);
            en      = 1'b1;
            data_in = pw[i];
        end
    endtask

    task automatic send(input bytes_t pw);
        sb.push_back(model(pw));
        stream(pw);
        @(negedge clk);
        en      = 1'b0;
        data_in = 8'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            en      = 1'b0;
            data_in = 8'($urandom);
        end
    endtask

    function automatic bytes_t rand_pw(input int len);
        bytes_t q;
        for (int i = 0; i < len; i++) begin
            int k = $urandom_range(0, 3);
            logic [7:0] ch;
            if (k == 0)      ch = 8'($urandom);
            else if (k == 1) ch = 8'("A" + $urandom_range(0, 25));
            else             ch = 8'("a" + $urandom_range(0, 25));
            q.push_back(ch);
        end
        return q;
    endfunction

    initial begin
        bytes_t big;
        idle(2);
        do_reset(2);
        idle(4);

        send(str2q("abcdefandre"));
        idle(3);
        send(str2q("Bc1!"));
        idle(2);
        send(str2q("aebcd"));
        send(str2q("xy"));
        idle(2);
        send(str2q("U"));
        idle(1);

        // Abort mid-password with reset held while en is still high.
        stream(str2q("aab"));
        @(negedge clk);
        reset   = 1'b0;
        en      = 1'b1;
        data_in = "e";
        sb.push_back(zero_exp());
        @(negedge clk);
        reset = 1'b1;
        en    = 1'b0;
        send(str2q("eibcd"));
        idle(2);

        for (int i = 0; i < 300; i++) big.push_back("a");
        send(big);
        idle(2);

        for (int i = 0; i < 30; i++) begin
            send(rand_pw($urandom_range(1, 20)));
            idle($urandom_range(0, 2));
        end

        idle(4);
        if (sb.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: %0d expected results never observed, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
